// File: rtl/pipeline_pkg.sv
// Shared types for the memory-port arbiter.
//   arb_state_e   : arbiter FSM states
//   arb_owner_e   : which requester owns the in-flight transaction
//   mem_bus_req_t : one memory request (we/be/addr/wdata), used both for the
//                   latched grant and for the mem_* output bundle
// The bus struct is sized by BUS_ADDR_W/BUS_DATA_W. A top-level width
// override must be matched by changing these constants.
package pipeline_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = BUS_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic                  we;
    logic [BUS_BE_W-1:0]   be;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } mem_bus_req_t;

  // Instruction fetch is always a full-word read.
  function automatic mem_bus_req_t if_bus_req(input logic [BUS_ADDR_W-1:0] addr);
    mem_bus_req_t r;
    r.we    = 1'b0;
    r.be    = '1;
    r.addr  = addr;
    r.wdata = '0;
    return r;
  endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Busy-cycle watchdog for the memory-port arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (asserted whenever the arbiter is not busy)
//   run        : count this cycle (asserted while the arbiter is busy)
//   expired    : high in the TIMEOUT-th consecutive run cycle; tied 0 when
//                TIMEOUT = 0
module arb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_disabled
    assign expired = 1'b0;
  end else begin : g_enabled
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // The count holds the number of completed run cycles, so the cycle that
    // sees LAST is the TIMEOUT-th one and expiry is flagged combinationally
    // within it. Saturating at LAST keeps a stalled run from wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_count <= '0;
      end else if (clear) begin
        r_count <= '0;
      end else if (run && (r_count != LAST)) begin
        r_count <= r_count + CW'(1);
      end
    end

    assign expired = run && (r_count == LAST);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch (IF) and the
// data-memory stage (DM). One transaction in flight; DM has fixed priority,
// but after STREAK_MAX back-to-back DM grants with IF waiting, IF is served.
//   if_*   : IF read requester (req/addr in, rdata/ack/err out)
//   dm_*   : DM read/write requester (req/we/be/addr/wdata in, rdata/ack/err out)
//   mem_*  : registered memory bus (req/we/be/addr/wdata out, rdata/ack in)
//   busy   : high whenever the FSM is not IDLE
// Flow: IDLE (grant, latch) -> BUSY (mem_req held until mem_ack or timeout)
//       -> RESP (one-cycle ack to the owner) -> IDLE.
module mem_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int ADDR_W     = BUS_ADDR_W,
  parameter int DATA_W     = BUS_DATA_W,
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  output logic                if_err,

  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                dm_err,

  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,

  output logic                busy
);

  localparam int SW = (STREAK_MAX < 2) ? 1 : $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);

  arb_state_e          r_state;
  arb_owner_e          r_owner;
  mem_bus_req_t        r_bus;
  logic [SW-1:0]       r_streak;
  logic                r_mem_req;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic                r_if_ack;
  logic                r_dm_ack;
  logic                r_if_err;
  logic                r_dm_err;

  logic                w_grant_if;
  logic                w_expired;
  logic                w_in_busy;
  logic [DATA_W-1:0]   w_rdata;

  assign w_in_busy = (r_state == BUSY);

  // IF only wins when DM is idle or DM has used up its streak while IF waited.
  assign w_grant_if = if_req && (!dm_req || (r_streak == STREAK_TOP));

  // A completion returns memory data only for reads; a timeout returns 0.
  assign w_rdata = (mem_ack && !r_bus.we) ? mem_rdata : '0;

  arb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!w_in_busy),
    .run     (w_in_busy),
    .expired (w_expired)
  );

  // NOTE: every register here is sequential state, so it is assigned with <=;
  // a blocking = would let later statements see the new value in the same
  // edge and break the one-cycle relationships between state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= OWN_IF;
      r_bus      <= '0;
      r_streak   <= '0;
      r_mem_req  <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_if_ack   <= 1'b0;
      r_dm_ack   <= 1'b0;
      r_if_err   <= 1'b0;
      r_dm_err   <= 1'b0;
    end else begin
      // Acks are single-cycle pulses; only the BUSY->RESP edge raises one.
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;

      case (r_state)
        IDLE: begin
          if (if_req || dm_req) begin
            r_state   <= BUSY;
            r_mem_req <= 1'b1;
            if (w_grant_if) begin
              r_owner  <= OWN_IF;
              r_bus    <= if_bus_req(if_addr);
              r_streak <= '0;
            end else begin
              r_owner <= OWN_DM;
              r_bus   <= '{we: dm_we, be: dm_be, addr: dm_addr, wdata: dm_wdata};
              if (!if_req) begin
                r_streak <= '0;
              end else if (r_streak != STREAK_TOP) begin
                r_streak <= r_streak + SW'(1);
              end
            end
          end
        end

        BUSY: begin
          // A mem_ack in the expiry cycle takes precedence over the timeout.
          if (mem_ack || w_expired) begin
            r_state   <= RESP;
            r_mem_req <= 1'b0;
            if (r_owner == OWN_DM) begin
              r_dm_rdata <= w_rdata;
              r_dm_err   <= !mem_ack;
              r_dm_ack   <= 1'b1;
            end else begin
              r_if_rdata <= w_rdata;
              r_if_err   <= !mem_ack;
              r_if_ack   <= 1'b1;
            end
          end
        end

        RESP: begin
          r_state <= IDLE;
        end

        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_bus.we;
  assign mem_be    = r_bus.be;
  assign mem_addr  = r_bus.addr;
  assign mem_wdata = r_bus.wdata;

  assign if_rdata  = r_if_rdata;
  assign if_ack    = r_if_ack;
  assign if_err    = r_if_err;
  assign dm_rdata  = r_dm_rdata;
  assign dm_ack    = r_dm_ack;
  assign dm_err    = r_dm_err;

  assign busy      = (r_state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction-fetch requester (IF) and the data-access requester of the memory stage (DM).
- Carries one outstanding transaction at a time. DM has fixed priority, and a streak limit prevents IF starvation.
- Registers the granted request onto the memory bus and returns registered read data with a one-cycle ack pulse.
- Applies a timeout to unresponsive memory and reports it as an error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STREAK_MAX, 4, consecutive DM grants allowed while IF waits; must be ≥1.
- TIMEOUT, 255, cycles in BUSY before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  IF request; held until if_ack.
- if_addr  in  ADDR_W  IF address; read only.
- if_rdata  out  DATA_W  IF read data; valid with if_ack.
- if_ack  out  1  one-cycle IF completion pulse.
- if_err  out  1  IF timeout flag; valid with if_ack.
- dm_req  in  1  DM request; held until dm_ack.
- dm_we  in  1  DM write enable.
- dm_be  in  DATA_W/8  DM byte enables.
- dm_addr  in  ADDR_W  DM address.
- dm_wdata  in  DATA_W  DM write data.
- dm_rdata  out  DATA_W  DM read data; valid with dm_ack.
- dm_ack  out  1  one-cycle DM completion pulse.
- dm_err  out  1  DM timeout flag; valid with dm_ack.
- mem_req  out  1  memory request; held until mem_ack or timeout.
- mem_we  out  1  memory write enable.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; sampled when mem_ack=1.
- mem_ack  in  1  memory completion; arbitrary latency, ≥1 cycle after mem_req rises.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE; owner cleared; streak and timer counters = 0.
  - Every output = 0, including the mem_* bus and the rdata registers.
  - An in-flight transaction is abandoned; no ack is issued for it.
- State IDLE:
  - If either req is high, latch the owner and that requester's request fields into the bus registers; next state BUSY.
  - Arbitration: DM wins, except when both requesters are high and streak == STREAK_MAX; then IF wins.
  - IF requests drive mem_we=0, mem_be=all-ones and mem_wdata=0.
- State BUSY:
  - mem_req=1 and all mem_* outputs are stable from the latched registers.
  - Timer increments each BUSY cycle.
  - On mem_ack: capture mem_rdata into the owner's rdata register (0 for writes); err=0; next state RESP.
  - If the timer reaches TIMEOUT (TIMEOUT≠0) without mem_ack: rdata=0, err=1; next state RESP.
  - mem_ack in the same cycle as expiry: the ack wins and err=0.
- State RESP:
  - mem_req=0; the owner's ack=1 for exactly this cycle; err valid.
  - The non-owner's ack stays 0.
  - Next state IDLE unconditionally, giving one idle cycle between transactions.
- Latency:
  - req seen in IDLE at cycle N → mem_req=1 at N+1.
  - mem_ack at cycle M → owner ack at M+1.
  - Minimum request-to-ack is 3 cycles.
- Streak counter, updated at grant:
  - DM granted while if_req=1: streak increments, saturating at STREAK_MAX.
  - IF granted, or DM granted while if_req=0: streak = 0.
- Stray inputs:
  - mem_ack outside BUSY is ignored.
  - Requester field changes after grant have no effect.
  - A requester dropping req mid-transaction does not cancel it; its ack is still pulsed.
- Outputs only change with state; rdata holds its value until the next capture.

Decomposition:
- pipeline_pkg holds:
  - arb_state_e enum {IDLE, BUSY, RESP}.
  - arb_owner_e enum {OWN_IF, OWN_DM}.
  - mem_bus_req_t struct {we, be, addr, wdata}, used both for the latched request and for the mem_* output bundle.
- Sub-module arb_timeout_ctr (parameter TIMEOUT):
  - Inputs clk, rst_n, clear, run.
  - Output expired; held 0 when TIMEOUT=0.

Test Plan:
- Single DM write, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_be=0xF, memory acks 2 cycles after mem_req → mem_* matches inputs; dm_ack pulses once, 1 cycle after mem_ack; dm_err=0; if_ack stays 0.
- Simultaneous if_req and dm_req, STREAK_MAX=4, both held continuously → grant order DM,DM,DM,DM,IF,DM…; streak returns to 0 after the IF grant.
- IF read at 0x40, memory returns 0x12345678 → if_rdata=0x12345678 with if_ack; mem_we=0, mem_be=0xF.
- TIMEOUT=8, memory never acks → mem_req high for exactly 8 cycles, then owner ack with err=1 and rdata=0; next request proceeds normally.
- Boundary cases:
  - mem_ack in the expiry cycle → err=0 and data captured.
  - mem_ack while IDLE → no ack, no state change.
  - rst_n low mid-BUSY → all outputs 0 immediately; late mem_ack ignored; no ack issued.
